// File: rtl/bsg_miniblade_wh_to_mem.sv
// bsg_miniblade_wh_to_mem: east-edge wormhole terminator for a vcache row.
// DMA fill/evict packets become beats on a single-port memory interface.
module bsg_miniblade_wh_to_mem #(
  parameter int wh_flit_width_p = 64,
  parameter int wh_cid_width_p = 2,
  parameter int wh_len_width_p = 4,
  parameter int wh_cord_width_p = 4,
  parameter int addr_width_p = 32,
  parameter int burst_len_p = 2,
  parameter int rd_fifo_els_p = 2,
  localparam int link_sif_width_lp = wh_flit_width_p + 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [wh_cord_width_p-1:0]   my_wh_cord_i,
  input  logic [link_sif_width_lp-1:0] wh_link_sif_i,
  output logic [link_sif_width_lp-1:0] wh_link_sif_o,
  output logic                         mem_v_o,
  output logic                         mem_w_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic [wh_flit_width_p-1:0]   mem_data_o,
  input  logic                         mem_yumi_i,
  input  logic                         mem_data_v_i,
  input  logic [wh_flit_width_p-1:0]   mem_data_i
);
  localparam int W = wh_flit_width_p;
  localparam int C = wh_cord_width_p;
  localparam int L = wh_len_width_p;
  localparam int I = wh_cid_width_p;
  localparam int A = addr_width_p;
  localparam int H = 2*C + L + 2*I + 1;
  localparam int BW = $clog2(burst_len_p + 1);
  localparam int FW = $clog2(rd_fifo_els_p + 1);
  localparam int PW = $clog2(rd_fifo_els_p);
  localparam logic [A-1:0] STRIDE = A'(W / 8);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] WR      = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_HDR  = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;

  logic         in_v, in_ready, out_v, out_ready;
  logic [W-1:0] in_data, out_data, hdr;

  assign in_v      = wh_link_sif_i[W+1];
  assign in_data   = wh_link_sif_i[W:1];
  assign out_ready = wh_link_sif_i[0];
  assign wh_link_sif_o = {out_v, out_data, in_ready};

  logic [2:0]    st_q, st_d;
  logic          up_q, wnr_q;
  logic [C-1:0]  src_cord_q;
  logic [I-1:0]  src_cid_q, cid_q;
  logic [A-1:0]  addr_q;
  logic [BW-1:0] beat_q, drain_q;
  logic [FW-1:0] out_q, cnt_q;
  logic [PW-1:0] wp_q, rp_q;
  logic [W-1:0]  fifo_q [rd_fifo_els_p];

  logic in_fire, mem_fire, rd_credit, rd_more;
  logic push, pop, rd_fire;

  assign in_fire  = in_v & in_ready;
  assign mem_fire = mem_v_o & mem_yumi_i;
  assign rd_fire  = mem_fire & ~mem_w_o;
  assign push     = mem_data_v_i;
  assign pop      = (st_q == RD_DATA) & out_v & out_ready;
  assign mem_addr_o = addr_q;

  // credit covers reads in flight plus buffered data
  assign rd_credit = ({1'b0, out_q} + {1'b0, cnt_q})
                   < (FW+1)'(rd_fifo_els_p);
  assign rd_more = beat_q != BW'(burst_len_p);

  always_comb begin
    hdr = '0;
    hdr[H-1:0] = {cid_q, my_wh_cord_i, 1'b0, src_cid_q,
                  L'(burst_len_p), src_cord_q};
  end

  // read requests keep issuing behind the reply so a small fifo cannot stall
  always_comb begin
    st_d       = st_q;
    in_ready   = 1'b0;
    out_v      = 1'b0;
    out_data   = fifo_q[rp_q];
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_data_o = in_data;
    unique case (st_q)
      IDLE: begin
        in_ready = up_q;
        if (in_fire) st_d = ADDR;
      end
      ADDR: begin
        in_ready = 1'b1;
        if (in_v) st_d = wnr_q ? WR : RD_REQ;
      end
      WR: begin
        mem_v_o  = in_v;
        mem_w_o  = 1'b1;
        in_ready = mem_yumi_i;
        if (in_fire && beat_q == BW'(burst_len_p - 1))
          st_d = IDLE;
      end
      RD_REQ: begin
        mem_v_o = rd_more & rd_credit;
        if (!rd_credit ||
            (mem_fire && beat_q == BW'(burst_len_p - 1)))
          st_d = RD_HDR;
      end
      RD_HDR: begin
        mem_v_o  = rd_more & rd_credit;
        out_v    = 1'b1;
        out_data = hdr;
        if (out_ready) st_d = RD_DATA;
      end
      RD_DATA: begin
        mem_v_o = rd_more & rd_credit;
        out_v   = cnt_q != '0;
        if (pop && drain_q == BW'(burst_len_p - 1))
          st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(rd_fifo_els_p - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st_q       <= IDLE;
      up_q       <= 1'b0;
      wnr_q      <= 1'b0;
      src_cord_q <= '0;
      src_cid_q  <= '0;
      cid_q      <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      drain_q    <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      st_q <= st_d;
      up_q <= 1'b1;
      if (st_q == IDLE && in_fire) begin
        cid_q      <= in_data[C+L +: I];
        wnr_q      <= in_data[C+L+I];
        src_cord_q <= in_data[C+L+I+1 +: C];
        src_cid_q  <= in_data[2*C+L+I+1 +: I];
      end
      if (st_q == ADDR && in_v) begin
        addr_q  <= in_data[A-1:0];
        beat_q  <= '0;
        drain_q <= '0;
      end
      if (mem_fire) begin
        addr_q <= addr_q + STRIDE;
        beat_q <= beat_q + BW'(1);
      end
      if (pop) drain_q <= drain_q + BW'(1);
      out_q <= out_q + FW'(rd_fire) - FW'(push);
      cnt_q <= cnt_q + FW'(push) - FW'(pop);
      if (push) wp_q <= nxt(wp_q);
      if (pop) rp_q <= nxt(rp_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wp_q] <= mem_data_i;
  end

endmodule
